fifo_access_arb: RTL

FIFO_ACCESS_ARB -- requirements
Module: fifo_access_arb

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 34 +++
 rtl/fifo_access_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO access arbiter: issue FSM state
// encoding and the width of the optional per-writer grant counters.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between writer 0 and writer 1. The pointer
// favours the writer not granted most recently and moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr_q = 1 means writer 1 wins a tie; reset favours writer 0.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      if (|gnt) ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fifo_access_arb.sv
// Arbitrates two writers and one reader onto a single-port FIFO, issuing at
// most one operation per cycle. Optional grant counters: FIFO_ARB_STATS_EN.
module fifo_access_arb
  import fifo_arb_pkg::*;
#(
  parameter int addr  = 4,
  parameter int width = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [width-1:0] DI0,
  input  logic [width-1:0] DI1,
  output logic             Gnt0,
  output logic             Gnt1,
  input  logic             RdReq,
  output logic             RdGnt,
  output logic             WE,
  output logic             RE,
  output logic [width-1:0] DI,
  input  logic             FF,
  input  logic             EF,
  input  logic             HF,
  input  logic [addr:0]    Cnt,
  output state_t           dbg_state
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] GntCnt0,
  output logic [STAT_W-1:0] GntCnt1
`endif
);

  localparam logic [addr:0] CNT_FULL_M1 = (addr+1)'(2**addr - 1);
  localparam logic [addr:0] CNT_ONE     = (addr+1)'(1);

  // Handshake: Req0/Req1/RdReq are held high until the matching one-cycle
  // grant; the FIFO enable (WE/RE) follows its grant exactly one cycle later.
  state_t           state_q, state_d;
  logic [width-1:0] di_q, di_d;
  logic             wr_ok, rd_ok;
  logic             wr_sel, rd_sel;
  logic [1:0]       arb_gnt;

  assign WE        = (state_q == WRITE);
  assign RE        = (state_q == READ);
  assign DI        = di_q;
  assign dbg_state = state_q;

  // Guard terms cover the operation issued last cycle that the flags and
  // occupancy have not yet reflected.
  assign wr_ok = !FF && !(WE && (Cnt == CNT_FULL_M1));
  assign rd_ok = !EF && !(RE && (Cnt == CNT_ONE));

  rr_arb2 u_rr (
    .clk (Clk),
    .rst (Rst),
    .req ({Req1, Req0}),
    .en  (wr_sel),
    .gnt (arb_gnt)
  );

  always_comb begin
    wr_sel = 1'b0;
    rd_sel = 1'b0;
    if (!Rst) begin
      if (HF && RdReq && rd_ok)           rd_sel = 1'b1;
      else if ((Req0 || Req1) && wr_ok)   wr_sel = 1'b1;
      else if (RdReq && rd_ok)            rd_sel = 1'b1;
    end

    state_d = IDLE;
    if (wr_sel)      state_d = WRITE;
    else if (rd_sel) state_d = READ;

    Gnt0  = arb_gnt[0];
    Gnt1  = arb_gnt[1];
    RdGnt = rd_sel;

    di_d = di_q;
    if (arb_gnt[1])      di_d = DI1;
    else if (arb_gnt[0]) di_d = DI0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      di_q    <= di_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt0_d;
  logic [STAT_W-1:0] cnt1_q, cnt1_d;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (Gnt0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (Gnt1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign GntCnt0 = cnt0_q;
  assign GntCnt1 = cnt1_q;
`endif

endmodule
